// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter. After reset it sweeps all 32 registers (SP gets SP_INIT),
// then arbitrates two writeback requesters with a 1-bit round-robin pointer.
module reg_write_arbiter #(
  parameter logic [31:0] SP_INIT = 32'h00001FFF
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Init_Req,
  input  logic        A_Valid,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  output logic        A_Ready,
  input  logic        B_Valid,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  output logic        B_Ready,
  output logic        Reg_Write,
  output logic [4:0]  Write_Reg,
  output logic [31:0] Write_Data,
  output logic        Init_Busy,
  output logic [15:0] Write_Count
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic       PTR_A   = 1'b0;
  localparam logic       PTR_B   = 1'b1;

  logic [0:0]  state;
  logic [4:0]  cnt;
  logic        rr_ptr;
  logic        accept_en;
  logic        grant_a;
  logic        grant_b;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    accept_en = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (state == ST_RUN && !Init_Req) begin
      accept_en = 1'b1;
    end
    if (accept_en) begin
      grant_a = A_Valid && (!B_Valid || rr_ptr == PTR_A);
      grant_b = B_Valid && (!A_Valid || rr_ptr == PTR_B);
    end
  end

  assign A_Ready   = grant_a;
  assign B_Ready   = grant_b;
  assign sel_reg   = grant_b ? B_Reg  : A_Reg;
  assign sel_data  = grant_b ? B_Data : A_Data;
  assign Init_Busy = (state == ST_INIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_INIT;
      cnt         <= '0;
      rr_ptr      <= PTR_A;
      Reg_Write   <= 1'b0;
      Write_Reg   <= '0;
      Write_Data  <= '0;
      Write_Count <= '0;
    end else if (state == ST_INIT) begin
      Reg_Write  <= 1'b1;
      Write_Reg  <= cnt;
      Write_Data <= (cnt == 5'd29) ? SP_INIT : 32'h0;
      cnt        <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        state <= ST_RUN;
      end
    end else if (Init_Req) begin
      // Readies are already forced low this cycle, so nothing in flight is dropped.
      state     <= ST_INIT;
      cnt       <= '0;
      Reg_Write <= 1'b0;
    end else if (grant_a || grant_b) begin
      Reg_Write  <= (sel_reg != 5'd0);
      Write_Reg  <= sel_reg;
      Write_Data <= sel_data;
      rr_ptr     <= grant_a ? PTR_B : PTR_A;
      if (sel_reg != 5'd0 && Write_Count != 16'hFFFF) begin
        Write_Count <= Write_Count + 16'd1;
      end
    end else begin
      Reg_Write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: each driven cycle pushes the expected registered
// write outputs, which are popped and compared one clock later.
module tb_reg_write_arbiter;

  localparam logic [31:0] SP = 32'h00001FFF;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Init_Req = 1'b0;
  logic        A_Valid = 1'b0, B_Valid = 1'b0;
  logic [4:0]  A_Reg = '0, B_Reg = '0;
  logic [31:0] A_Data = '0, B_Data = '0;
  logic        A_Ready, B_Ready, Reg_Write, Init_Busy;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic [15:0] Write_Count;

  reg_write_arbiter #(.SP_INIT(SP)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Init_Req(Init_Req),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Reg(B_Reg), .B_Data(B_Data), .B_Ready(B_Ready),
    .Reg_Write(Reg_Write), .Write_Reg(Write_Reg), .Write_Data(Write_Data),
    .Init_Busy(Init_Busy), .Write_Count(Write_Count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          init_idx = 0;
  logic [4:0]  last_reg = '0;
  logic [31:0] last_data = '0;
  logic [15:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational readies, push the expected
  // registered result, then clock and compare against the scoreboard head.
  task automatic run_cycle(input string tag,
                           input logic av, input logic [4:0] ar, input logic [31:0] ad,
                           input logic bv, input logic [4:0] br, input logic [31:0] bd,
                           input logic ir, input logic exp_ar, input logic exp_br,
                           input logic exp_busy);
    wr_t e;
    wr_t got;
    A_Valid = av; A_Reg = ar; A_Data = ad;
    B_Valid = bv; B_Reg = br; B_Data = bd;
    Init_Req = ir;
    #1;
    check({tag, "_a_ready"}, 32'(A_Ready), 32'(exp_ar));
    check({tag, "_b_ready"}, 32'(B_Ready), 32'(exp_br));
    check({tag, "_busy"}, 32'(Init_Busy), 32'(exp_busy));
    if (exp_busy) begin
      e = '{1'b1, 5'(init_idx), (init_idx == 29) ? SP : 32'h0};
      init_idx++;
    end else if (exp_ar || exp_br) begin
      e.idx  = exp_ar ? ar : br;
      e.data = exp_ar ? ad : bd;
      e.we   = (e.idx != 5'd0);
      if (e.we && exp_count != 16'hFFFF) exp_count++;
    end else begin
      e = '{1'b0, last_reg, last_data};
      if (ir) init_idx = 0;
    end
    last_reg  = e.idx;
    last_data = e.data;
    sb_q.push_back(e);
    @(posedge Clock);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_we"}, 32'(Reg_Write), 32'(got.we));
      check({tag, "_reg"}, 32'(Write_Reg), 32'(got.idx));
      check({tag, "_data"}, Write_Data, got.data);
    end
    check({tag, "_count"}, 32'(Write_Count), 32'(exp_count));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"}, 32'(Reg_Write), 32'd0);
    check({tag, "_reg"}, 32'(Write_Reg), 32'd0);
    check({tag, "_data"}, Write_Data, 32'd0);
    check({tag, "_count"}, 32'(Write_Count), 32'd0);
    check({tag, "_busy"}, 32'(Init_Busy), 32'd1);
    check({tag, "_a_ready"}, 32'(A_Ready), 32'd0);
    check({tag, "_b_ready"}, 32'(B_Ready), 32'd0);
  endtask

  initial begin
    // Reset with both requesters valid: readies must stay low.
    A_Valid = 1'b1; A_Reg = 5'd1; A_Data = 32'hA0;
    B_Valid = 1'b1; B_Reg = 5'd2; B_Data = 32'hB0;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_state("rst");
    Reset_n = 1'b1;

    // Init sweep with both requesters pending and an Init_Req that must be ignored.
    for (int i = 0; i < 32; i++)
      run_cycle("init", 1, 5'd1, 32'hA0, 1, 5'd2, 32'hB0, (i == 5), 0, 0, 1);

    // Both valid from the first RUN cycle: grants alternate A,B,A,B.
    run_cycle("rr0", 1, 5'd1, 32'hA0, 1, 5'd2, 32'hB0, 0, 1, 0, 0);
    run_cycle("rr1", 1, 5'd3, 32'hA1, 1, 5'd2, 32'hB0, 0, 0, 1, 0);
    run_cycle("rr2", 1, 5'd3, 32'hA1, 1, 5'd4, 32'hB1, 0, 1, 0, 0);
    run_cycle("rr3", 1, 5'd6, 32'hA2, 1, 5'd4, 32'hB1, 0, 0, 1, 0);
    run_cycle("idle0", 0, 5'd6, 32'hA2, 0, 5'd4, 32'hB1, 0, 0, 0, 0);

    // Single requester A, then a dropped write to r0 from B.
    run_cycle("a_only", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 1, 0, 0);
    run_cycle("idle1", 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 0, 0, 0);
    run_cycle("b_r0", 0, 5'd5, 32'h0, 1, 5'd0, 32'h12345678, 0, 0, 1, 0);
    run_cycle("idle2", 0, 5'd5, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0);

    // Pointer now at A after the B grant.
    run_cycle("rr4", 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, 1, 0, 0);
    run_cycle("rr5", 0, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, 0, 1, 0);
    run_cycle("b_only", 0, 5'd0, 32'h0, 1, 5'd31, 32'hCAFEF00D, 0, 0, 1, 0);

    // Init_Req in RUN blocks A, re-runs init, then A wins the first RUN cycle.
    run_cycle("ireq", 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      run_cycle("reinit", 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0, 0, 0, 1);
    run_cycle("post_init", 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0, 1, 0, 0);

    // Reset pulse mid-INIT right after the write for index 10.
    run_cycle("ireq2", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      run_cycle("init_part", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 1);
    check("pre_abort_reg", 32'(Write_Reg), 32'd10);
    Reset_n = 1'b0;
    #1;
    check_reset_state("abort");
    sb_q.delete();
    init_idx = 0; last_reg = '0; last_data = '0; exp_count = '0;
    @(posedge Clock);
    #1;
    check("abort_hold_we", 32'(Reg_Write), 32'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 32; i++)
      run_cycle("init3", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 1);

    // Pointer restored to A by reset.
    run_cycle("rr6", 1, 5'd10, 32'h1010, 1, 5'd11, 32'h1111, 0, 1, 0, 0);
    run_cycle("rr7", 0, 5'd10, 32'h1010, 1, 5'd11, 32'h1111, 0, 0, 1, 0);
    run_cycle("idle3", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: SP_INIT, 32'h00001FFF, value written to register 29 (stack pointer) during init; all other registers are written with 0.
REQ-002 Port: Clock  in  1  single clock; all state updates on posedge.
REQ-003 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: Init_Req  in  1  request to re-run the register-file init sequence.
REQ-005 Port: A_Valid  in  1  requester A (ALU writeback) has a write pending.
REQ-006 Port: A_Reg  in  5  destination register index for requester A.
REQ-007 Port: A_Data  in  32  write data for requester A.
REQ-008 Port: A_Ready  out  1  requester A accepted this cycle (combinational).
REQ-009 Port: B_Valid  in  1  B_Reg  in  5  B_Data  in  32  B_Ready  out  1  requester B (load writeback); same meaning as the A ports.
REQ-010 Port: Reg_Write  out  1  register-file write enable (registered).
REQ-011 Port: Write_Reg  out  5  register-file write index (registered).
REQ-012 Port: Write_Data  out  32  register-file write data (registered).
REQ-013 Port: Init_Busy  out  1  high while in the INIT state.
REQ-014 Port: Write_Count  out  16  count of committed non-zero-register writes in RUN; saturates at 16'hFFFF.

Function
REQ-015 The FSM SHALL have two states: INIT and RUN, plus a 5-bit init counter cnt.
REQ-016 In INIT, each posedge SHALL register Reg_Write=1, Write_Reg=cnt, and Write_Data=(cnt==29 ? SP_INIT : 0), then increment cnt.
REQ-017 After the posedge that issues the write for cnt==31, the FSM SHALL move to RUN; INIT therefore lasts exactly 32 cycles.
REQ-018 In INIT, A_Ready and B_Ready SHALL be 0, and Init_Req SHALL be ignored (no restart).
REQ-019 In RUN with Init_Req=0, the grant SHALL go to the only valid requester; if both are valid, it SHALL go to the requester selected by a 1-bit round-robin pointer.
REQ-020 X_Ready SHALL be 1 only for the granted requester; at most one Ready SHALL be high per cycle.
REQ-021 A handshake completes when Valid and Ready are both high at a posedge; after a handshake, the pointer SHALL point to the non-granted requester.
REQ-022 On a handshake, the next-cycle outputs SHALL be Write_Reg=X_Reg, Write_Data=X_Data, and Reg_Write=(X_Reg!=0); latency is one cycle from acceptance to Reg_Write.
REQ-023 A write to register 0 SHALL be accepted (Ready=1) but dropped: Reg_Write=0 and Write_Count unchanged.
REQ-024 In a RUN cycle with no handshake, Reg_Write SHALL be 0, and Write_Reg and Write_Data SHALL hold their previous values.
REQ-025 Reg_Write SHALL be a registered level held for the full cycle, so that a negedge-sampling register file captures it.
REQ-026 Requesters SHALL hold Valid, Reg, and Data stable until Ready; the arbiter does not buffer.
REQ-027 Init_Req=1 in RUN SHALL force both Ready outputs to 0 combinationally (no accepted write is lost) and SHALL enter INIT with cnt=0 at the next posedge.
REQ-028 Write_Count SHALL increment on each RUN handshake with X_Reg!=0, and SHALL hold at 16'hFFFF once reached.

Reset
REQ-029 While Reset_n=0, the block SHALL asynchronously set state=INIT, cnt=0, pointer=A, Reg_Write=0, Write_Reg=0, Write_Data=0, Write_Count=0, and A_Ready=B_Ready=0.
REQ-030 Reset_n asserted mid-INIT or mid-RUN SHALL abort immediately; after release, init SHALL restart from register 0.

Verification
REQ-031 Release reset -> 32 consecutive cycles with Reg_Write=1 and Write_Reg=0..31; Write_Data=0 except 32'h00001FFF at index 29; Init_Busy falls after the last write.
REQ-032 In RUN, A only: A_Valid=1, A_Reg=5, A_Data=32'hDEADBEEF -> A_Ready=1 the same cycle; the next cycle shows Reg_Write=1, Write_Reg=5, Write_Data=32'hDEADBEEF; Write_Count=1.
REQ-033 Both A and B valid for 4 cycles, first RUN cycle -> grants A,B,A,B; B_Ready is never high together with A_Ready.
REQ-034 B_Reg=0, B_Data=32'h12345678, B_Valid=1 -> B_Ready=1; Reg_Write stays 0; Write_Count unchanged.
REQ-035 Init_Req=1 with A_Valid=1 -> A_Ready=0; a 32-write init sequence follows; A is granted in the first RUN cycle afterwards.
REQ-036 Reset_n pulsed low after the write for index 10 in INIT -> outputs go to 0 immediately; after release, Write_Reg restarts at 0.
